// File: rtl/spu_sm_norm_pkg.sv
// rtl/spu_sm_norm_pkg.sv - shared types and constants for the softmax normalizer
package spu_sm_norm_pkg;

    localparam int LANES      = 8;
    localparam int XW         = 8;
    localparam int SW         = 20;
    localparam int RW         = 29;
    localparam int DIV_CYCLES = 29;
    localparam int P_SHIFT    = 20;
    localparam int P_MAX      = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV    = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

endpackage

// File: rtl/spu_sm_norm_if.sv
// rtl/spu_sm_norm_if.sv - sum, input-beat and output-beat streams of the normalizer
interface spu_sm_norm_if #(
    parameter int LANES = 8,
    parameter int XW    = 8,
    parameter int SW    = 20
);
    logic [SW-1:0] sum_in;
    logic          sum_valid;
    logic [XW-1:0] in_x [LANES];
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [XW-1:0] p [LANES];
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        output sum_in, sum_valid, in_x, in_valid, in_last, out_ready,
        input  in_ready, p, out_valid, out_last
    );

    modport slave (
        input  sum_in, sum_valid, in_x, in_valid, in_last, out_ready,
        output in_ready, p, out_valid, out_last
    );
endinterface

// File: rtl/spu_sm_recip_div.sv
// rtl/spu_sm_recip_div.sv - restoring divider, one quotient bit per cycle, MSB first
module spu_sm_recip_div
    import spu_sm_norm_pkg::*;
#(
    parameter int SW = 20,
    parameter int RW = 29
) (
    input  logic          core_clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          clr,
    input  logic [RW-1:0] dividend,
    input  logic [SW-1:0] divisor,
    output logic          done,
    output logic [RW-1:0] quotient
);
    localparam int CW = $clog2(RW);

    logic          run_q, run_d;
    logic          done_q, done_d;
    logic          zero_q, zero_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] div_q, div_d;
    logic [SW-1:0] rem_q, rem_d;
    logic [RW-1:0] quo_q, quo_d;
    logic [RW-1:0] dvd_q, dvd_d;
    logic [SW:0]   trial;

    always_comb begin
        run_d  = run_q;
        done_d = 1'b0;
        zero_d = zero_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvd_d  = dvd_q;
        // Remainder stays below the divisor, so the shifted trial fits SW+1 bits.
        trial  = {rem_q, dvd_q[RW-1]};
        if (clr) begin
            run_d  = 1'b0;
            zero_d = 1'b0;
            cnt_d  = '0;
            div_d  = '0;
            rem_d  = '0;
            quo_d  = '0;
            dvd_d  = '0;
        end else if (start) begin
            run_d  = 1'b1;
            zero_d = (divisor == '0);
            cnt_d  = CW'(DIV_CYCLES - 1);
            div_d  = divisor;
            rem_d  = '0;
            quo_d  = '0;
            dvd_d  = dividend;
        end else if (run_q) begin
            if (trial >= {1'b0, div_q}) begin
                rem_d = SW'(trial - {1'b0, div_q});
                quo_d = {quo_q[RW-2:0], 1'b1};
            end else begin
                rem_d = trial[SW-1:0];
                quo_d = {quo_q[RW-2:0], 1'b0};
            end
            dvd_d = {dvd_q[RW-2:0], 1'b0};
            if (cnt_q == '0) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            zero_q <= 1'b0;
            cnt_q  <= '0;
            div_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvd_q  <= '0;
        end else begin
            run_q  <= run_d;
            done_q <= done_d;
            zero_q <= zero_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvd_q  <= dvd_d;
        end
    end

    assign done     = done_q;
    assign quotient = zero_q ? '0 : quo_q;

endmodule

// File: rtl/spu_sm_norm.sv
// rtl/spu_sm_norm.sv - softmax normalizer: reciprocal of the row sum, then per-lane scale
module spu_sm_norm
    import spu_sm_norm_pkg::*;
#(
    parameter int LANES = spu_sm_norm_pkg::LANES,
    parameter int XW    = spu_sm_norm_pkg::XW,
    parameter int SW    = spu_sm_norm_pkg::SW,
    parameter int RW    = spu_sm_norm_pkg::RW
) (
    input  logic          core_clk,
    input  logic          rst_n,
    input  logic          en,
    spu_sm_norm_if.slave  bus,
    output logic          busy,
    output logic          err_zero
);
    localparam int PW = XW + RW;
    localparam logic [RW-1:0] RECIP_ONE = {1'b1, {(RW-1){1'b0}}};

    state_e        state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          err_zero_q, err_zero_d;
    logic [XW-1:0] p_q [LANES];
    logic [XW-1:0] p_d [LANES];
    logic [XW-1:0] lane_p [LANES];
    logic [RW-1:0] recip;
    logic          div_start, div_clr, div_done;
    logic          in_ready, in_fire, out_fire;

    spu_sm_recip_div #(.SW(SW), .RW(RW)) u_div (
        .core_clk (core_clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .clr      (div_clr),
        .dividend (RECIP_ONE),
        .divisor  (bus.sum_in),
        .done     (div_done),
        .quotient (recip)
    );

    // Full-width product so x == sum lands exactly on the saturation point.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [PW-1:0] prod;
        logic [PW-1:0] scaled;
        assign prod      = PW'(bus.in_x[g]) * PW'(recip);
        assign scaled    = prod >> P_SHIFT;
        assign lane_p[g] = (scaled > PW'(P_MAX)) ? XW'(P_MAX) : scaled[XW-1:0];
        assign bus.p[g]  = p_q[g];
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_zero_d  = err_zero_q;
        p_d         = p_q;
        div_start   = 1'b0;
        div_clr     = 1'b0;
        in_ready    = (state_q == ST_STREAM) && (!out_valid_q || bus.out_ready);
        in_fire     = in_ready && bus.in_valid;
        out_fire    = out_valid_q && bus.out_ready;
        if (!en) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            p_d         = '{default: '0};
            div_clr     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.sum_valid) begin
                        div_start  = 1'b1;
                        err_zero_d = (bus.sum_in == '0);
                        state_d    = ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (div_done) state_d = ST_STREAM;
                end
                ST_STREAM: begin
                    if (in_fire) begin
                        out_valid_d = 1'b1;
                        out_last_d  = bus.in_last;
                        p_d         = lane_p;
                    end else if (out_fire) begin
                        out_valid_d = 1'b0;
                    end
                    if (out_fire && out_last_q) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_zero_q  <= 1'b0;
            p_q         <= '{default: '0};
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_zero_q  <= err_zero_d;
            p_q         <= p_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q != ST_IDLE);
    assign err_zero      = err_zero_q;

endmodule

// File: tb/tb_spu_sm_norm.sv
// tb/tb_spu_sm_norm.sv - scoreboard bench for spu_sm_norm with directed rows
module tb_spu_sm_norm;

    typedef struct packed {
        logic [63:0] p;
        logic        last;
    } exp_t;

    logic core_clk = 1'b0;
    logic rst_n    = 1'b0;
    logic en       = 1'b1;
    logic busy, err_zero;

    int   total = 0;
    int   bad   = 0;
    int   rdy_mode = 0;
    exp_t sb [$];

    spu_sm_norm_if #(.LANES(8), .XW(8), .SW(20)) bus ();

    spu_sm_norm dut (
        .core_clk (core_clk),
        .rst_n    (rst_n),
        .en       (en),
        .bus      (bus.slave),
        .busy     (busy),
        .err_zero (err_zero)
    );

    always #5 core_clk = ~core_clk;

    function automatic logic [63:0] pack_p();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = bus.p[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    // out_ready source: 0 = always ready, 1 = pattern 1,0,0,1, 2 = held low
    initial begin
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge core_clk);
            #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b1;
                1: begin bus.out_ready = pat[k]; k = (k + 1) % 4; end
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pop on every consumed beat; check stability across stalls.
    initial begin
        logic        held;
        logic [63:0] held_p, got;
        logic        held_last;
        exp_t        e;
        held = 1'b0;
        held_p = '0;
        held_last = 1'b0;
        forever begin
            @(negedge core_clk);
            if (rst_n && bus.out_valid) begin
                got = pack_p();
                if (held) begin
                    total++;
                    if (got !== held_p || bus.out_last !== held_last) begin
                        bad++;
                        $display("FAIL hold got=%0h/%0b want=%0h/%0b", got, bus.out_last, held_p, held_last);
                    end
                end
                if (bus.out_ready) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_beat got=%0h", got);
                    end else begin
                        e = sb.pop_front();
                        if (got !== e.p || bus.out_last !== e.last) begin
                            bad++;
                            $display("FAIL beat got=%0h/%0b want=%0h/%0b", got, bus.out_last, e.p, e.last);
                        end
                    end
                end
                held      = !bus.out_ready;
                held_p    = got;
                held_last = bus.out_last;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic accept_sum(input logic [19:0] s);
        int n;
        bus.sum_in = s;
        bus.sum_valid = 1'b1;
        tick();
        bus.sum_valid = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("in_ready_latency", 64'(n), 64'd30);
    endtask

    task automatic drive_beat(input logic [63:0] x, input logic last);
        int  n;
        logic acc;
        for (int i = 0; i < 8; i++) bus.in_x[i] = x[i*8 +: 8];
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge core_clk);
            acc = bus.in_ready;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!acc) chk("beat_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_beat(input logic [63:0] x, input logic last, input logic [63:0] p);
        exp_t e;
        drive_beat(x, last);
        e.p = p;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_queue", 64'(sb.size()), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        bus.sum_in = '0;
        bus.sum_valid = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        for (int i = 0; i < 8; i++) bus.in_x[i] = '0;

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_err_zero", 64'(err_zero), 64'd0);
        chk("rst_p", pack_p(), 64'd0);
        #11;
        rst_n = 1'b1;
        tick();

        // sum=1024 -> R=2^18, x=128 -> p=32
        accept_sum(20'd1024);
        chk("busy_stream", 64'(busy), 64'd1);
        send_beat(64'h8080_8080_8080_8080, 1'b0, 64'h2020_2020_2020_2020);
        send_beat(64'h8080_8080_8080_8080, 1'b1, 64'h2020_2020_2020_2020);
        drain();

        // sum=3 -> R=89478485
        accept_sum(20'd3);
        send_beat(64'h0000_0000_0003_0201, 1'b1, 64'h0000_0000_00FF_AA55);
        drain();

        // zero sum forces R=0, then sum=8 clears the flag (R=2^25)
        accept_sum(20'd0);
        chk("err_zero_set", 64'(err_zero), 64'd1);
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0);
        send_beat(64'h0102_0304_0506_0708, 1'b1, 64'd0);
        drain();
        chk("err_zero_sticky", 64'(err_zero), 64'd1);
        accept_sum(20'd8);
        chk("err_zero_clear", 64'(err_zero), 64'd0);
        send_beat(64'h0808_0808_0808_0808, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        send_beat(64'h0000_0000_FF01_0708, 1'b1, 64'h0000_0000_FF20_E0FF);
        drain();

        // stalled 4-beat row, x = 4*(k+1+i) -> p = k+1+i
        rdy_mode = 1;
        accept_sum(20'd1024);
        for (int k = 0; k < 4; k++) begin
            logic [63:0] x, p;
            for (int i = 0; i < 8; i++) begin
                p[i*8 +: 8] = 8'(k + 1 + i);
                x[i*8 +: 8] = 8'(4 * (k + 1 + i));
            end
            send_beat(x, (k == 3), p);
        end
        drain();
        rdy_mode = 0;

        // en dropped in DIV
        bus.sum_in = 20'd1024;
        bus.sum_valid = 1'b1;
        tick();
        bus.sum_valid = 1'b0;
        repeat (10) tick();
        chk("div_busy", 64'(busy), 64'd1);
        en = 1'b0;
        tick();
        chk("abort_div_busy", 64'(busy), 64'd0);
        chk("abort_div_in_ready", 64'(bus.in_ready), 64'd0);
        en = 1'b1;
        accept_sum(20'd3);
        send_beat(64'h0000_0000_0003_0201, 1'b1, 64'h0000_0000_00FF_AA55);
        drain();

        // en dropped mid-STREAM with a stalled beat held
        rdy_mode = 2;
        accept_sum(20'd1024);
        drive_beat(64'h8080_8080_8080_8080, 1'b0);
        chk("stream_out_valid", 64'(bus.out_valid), 64'd1);
        en = 1'b0;
        tick();
        chk("abort_stream_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_stream_busy", 64'(busy), 64'd0);
        chk("abort_stream_p", pack_p(), 64'd0);
        en = 1'b1;
        rdy_mode = 0;
        tick();
        accept_sum(20'd8);
        send_beat(64'h0808_0808_0808_0808, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();

        // asynchronous reset between edges while a beat is held
        rdy_mode = 2;
        accept_sum(20'd1024);
        drive_beat(64'h8080_8080_8080_8080, 1'b0);
        chk("pre_rst_p", pack_p(), 64'h2020_2020_2020_2020);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_p", pack_p(), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("async_rst_err_zero", 64'(err_zero), 64'd0);
        rdy_mode = 0;
        repeat (2) @(negedge core_clk);
        #1;
        rst_n = 1'b1;
        tick();
        accept_sum(20'd3);
        send_beat(64'h0000_0000_0003_0201, 1'b1, 64'h0000_0000_00FF_AA55);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

endmodule
